// File: rtl/xor_cfg_loader_if.sv
// Configuration port bundle for xor_cfg_loader: serial frame input, daisy-chain
// output, committed cipher settings and status flags.
interface xor_cfg_loader_if #(
  parameter int LFSR_W = 32
);
  logic              cfg_en;
  logic              cfg_i;
  logic              cfg_o;
  logic              cfg_err_clr;
  logic [LFSR_W-1:0] taps;
  logic [LFSR_W-1:0] seed;
  logic              cipher_en;
  logic              lfsr_load;
  logic              cfg_busy;
  logic              cfg_err;

  modport master (
    output cfg_en, cfg_i, cfg_err_clr,
    input  cfg_o, taps, seed, cipher_en, lfsr_load, cfg_busy, cfg_err
  );

  modport slave (
    input  cfg_en, cfg_i, cfg_err_clr,
    output cfg_o, taps, seed, cipher_en, lfsr_load, cfg_busy, cfg_err
  );
endinterface

// File: rtl/xor_cfg_loader.sv
// Serial configuration loader for the XOR cipher stage: shifts in a framed
// {cipher_en, seed, taps} word, validates it on frame close and commits it.
module xor_cfg_loader #(
  parameter int                LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] DEFAULT_TAPS = 32'h0000_0060,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 32'h0000_0001,
  parameter logic              DEFAULT_EN   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  xor_cfg_loader_if.slave    bus
);

  localparam int         FRAME_W   = 2 * LFSR_W + 1;
  localparam logic [6:0] FRAME_CNT = 7'(FRAME_W);
  localparam logic [6:0] CNT_MAX   = 7'd127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    LOAD  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  sr_q, sr_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [LFSR_W-1:0]   taps_q, taps_d;
  logic [LFSR_W-1:0]   seed_q, seed_d;
  logic                en_q, en_d;
  logic                load_q, load_d;
  logic                err_q, err_d;
  logic                frame_valid;
  logic [FRAME_W-1:0]  sr_shifted;

  assign sr_shifted  = {sr_q[FRAME_W-2:0], bus.cfg_i};
  assign frame_valid = (cnt_q == FRAME_CNT) && (|sr_q[2*LFSR_W-1:LFSR_W]);

  // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    taps_d  = taps_q;
    seed_d  = seed_q;
    en_d    = en_q;
    load_d  = load_q;
    err_d   = err_q;

    // Clear is applied first so a rejection in the same cycle overrides it.
    if (bus.cfg_err_clr) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.cfg_en) begin
          state_d = SHIFT;
          sr_d    = sr_shifted;
          cnt_d   = 7'd1;
        end
      end
      SHIFT: begin
        if (bus.cfg_en) begin
          sr_d  = sr_shifted;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 7'd1;
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        cnt_d = 7'd0;
        if (frame_valid) begin
          state_d = LOAD;
          taps_d  = sr_q[LFSR_W-1:0];
          seed_d  = sr_q[2*LFSR_W-1:LFSR_W];
          en_d    = sr_q[2*LFSR_W];
          load_d  = 1'b1;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      LOAD: begin
        load_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      taps_q  <= DEFAULT_TAPS;
      seed_q  <= DEFAULT_SEED;
      en_q    <= DEFAULT_EN;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      taps_q  <= taps_d;
      seed_q  <= seed_d;
      en_q    <= en_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign bus.cfg_o     = sr_q[FRAME_W-1];
  assign bus.taps      = taps_q;
  assign bus.seed      = seed_q;
  assign bus.cipher_en = en_q;
  assign bus.lfsr_load = load_q;
  assign bus.cfg_busy  = (state_q != IDLE);
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_xor_cfg_loader.sv
// Directed bench for xor_cfg_loader: valid/short/long/zero-seed frames, chain
// pass-through, mid-frame reset and cfg_err set/clear priority.
module tb_xor_cfg_loader;

  localparam int LFSR_W  = 32;
  localparam int FRAME_W = 2 * LFSR_W + 1;

  typedef struct packed {
    logic [LFSR_W-1:0] taps;
    logic [LFSR_W-1:0] seed;
    logic              en;
  } cfg_t;

  logic clk = 1'b0;
  logic rst;

  xor_cfg_loader_if #(.LFSR_W(LFSR_W)) bus ();

  xor_cfg_loader #(
    .LFSR_W      (LFSR_W),
    .DEFAULT_TAPS(32'h0000_0060),
    .DEFAULT_SEED(32'h0000_0001),
    .DEFAULT_EN  (1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  cfg_t sb_q[$];
  cfg_t mdl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_committed(input string tag);
    check({tag, "_taps"}, 64'(bus.taps), 64'(mdl.taps));
    check({tag, "_seed"}, 64'(bus.seed), 64'(mdl.seed));
    check({tag, "_en"},   64'(bus.cipher_en), 64'(mdl.en));
  endtask

  task automatic send_bits(input logic [129:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.cfg_en = 1'b1;
      bus.cfg_i  = v[i];
      step();
    end
    bus.cfg_en = 1'b0;
    bus.cfg_i  = 1'b0;
  endtask

  task automatic push_frame(input logic [FRAME_W-1:0] f);
    cfg_t e;
    e.en   = f[2*LFSR_W];
    e.seed = f[2*LFSR_W-1:LFSR_W];
    e.taps = f[LFSR_W-1:0];
    sb_q.push_back(e);
  endtask

  // Called right after the last shift edge with cfg_en already low.
  task automatic expect_load(input string tag);
    step();
    check({tag, "_load_n1"}, 64'(bus.lfsr_load), 64'd0);
    check({tag, "_busy_n1"}, 64'(bus.cfg_busy), 64'd1);
    step();
    check({tag, "_load_n2"}, 64'(bus.lfsr_load), 64'd1);
    check({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      mdl = sb_q.pop_front();
    end
    check_committed(tag);
    step();
    check({tag, "_load_n3"}, 64'(bus.lfsr_load), 64'd0);
    check({tag, "_busy_n3"}, 64'(bus.cfg_busy), 64'd0);
    step();
  endtask

  task automatic expect_reject(input string tag);
    step();
    check({tag, "_load_n1"}, 64'(bus.lfsr_load), 64'd0);
    step();
    check({tag, "_load_n2"}, 64'(bus.lfsr_load), 64'd0);
    check({tag, "_err"}, 64'(bus.cfg_err), 64'd1);
    check({tag, "_busy"}, 64'(bus.cfg_busy), 64'd0);
    check_committed(tag);
    step();
    check({tag, "_load_n3"}, 64'(bus.lfsr_load), 64'd0);
  endtask

  task automatic clear_err(input string tag);
    bus.cfg_err_clr = 1'b1;
    step();
    bus.cfg_err_clr = 1'b0;
    check({tag, "_err_clr"}, 64'(bus.cfg_err), 64'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    mdl.taps = 32'h0000_0060;
    mdl.seed = 32'h0000_0001;
    mdl.en   = 1'b0;
    sb_q.delete();
  endtask

  logic [FRAME_W-1:0] f_valid, f_zero, f_second;
  logic               pt_bits [130];

  initial begin
    rst             = 1'b1;
    bus.cfg_en      = 1'b0;
    bus.cfg_i       = 1'b0;
    bus.cfg_err_clr = 1'b0;

    // Reset state
    apply_reset();
    check_committed("rst");
    check("rst_load", 64'(bus.lfsr_load), 64'd0);
    check("rst_busy", 64'(bus.cfg_busy), 64'd0);
    check("rst_err",  64'(bus.cfg_err), 64'd0);
    check("rst_cfg_o", 64'(bus.cfg_o), 64'd0);

    // Valid frame
    f_valid = {1'b1, 32'h0000_ACE1, 32'h8020_0003};
    push_frame(f_valid);
    send_bits(130'(f_valid), FRAME_W);
    expect_load("valid");
    check("valid_err", 64'(bus.cfg_err), 64'd0);

    // Short (64) then long (66) frame
    send_bits(130'(f_valid[63:0]), 64);
    expect_reject("short");
    clear_err("short");
    send_bits(130'({1'b1, f_valid}), 66);
    expect_reject("long");
    clear_err("long");

    // Zero seed
    f_zero = {1'b1, 32'h0000_0000, 32'h1234_5678};
    send_bits(130'(f_zero), FRAME_W);
    expect_reject("zero_seed");
    clear_err("zero_seed");

    // Chain pass-through over 130 shifts
    for (int i = 0; i < 130; i++) pt_bits[i] = 1'($urandom);
    for (int i = 0; i < 130; i++) begin
      bus.cfg_en = 1'b1;
      bus.cfg_i  = pt_bits[i];
      step();
      if (i >= FRAME_W - 1) begin
        check($sformatf("pt_cfg_o_%0d", i), 64'(bus.cfg_o), 64'(pt_bits[i-(FRAME_W-1)]));
      end
    end
    bus.cfg_en = 1'b0;
    bus.cfg_i  = 1'b0;
    expect_reject("passthru");
    clear_err("passthru");

    // Reset at bit 40 of a valid frame
    f_second = {1'b0, 32'h1234_5678, 32'hDEAD_BEEF};
    send_bits(130'(f_second >> 25), 40);
    apply_reset();
    check_committed("midrst");
    check("midrst_busy", 64'(bus.cfg_busy), 64'd0);
    check("midrst_cfg_o", 64'(bus.cfg_o), 64'd0);
    check("midrst_err", 64'(bus.cfg_err), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("midrst_noload_%0d", i), 64'(bus.lfsr_load), 64'd0);
    end
    check_committed("midrst_hold");

    push_frame(f_second);
    send_bits(130'(f_second), FRAME_W);
    expect_load("after_rst");

    // Set and clear of cfg_err on the same edge
    check("prio_pre_err", 64'(bus.cfg_err), 64'd0);
    send_bits(130'(f_second[63:0]), 64);
    step();
    bus.cfg_err_clr = 1'b1;
    step();
    bus.cfg_err_clr = 1'b0;
    check("prio_err", 64'(bus.cfg_err), 64'd1);
    check_committed("prio");
    clear_err("prio");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor_cfg_loader.md
Name: xor_cfg_loader

Overview:
- Serial configuration loader directly upstream of the XOR cipher stage.
- Captures a framed bit stream on cfg_en/cfg_i and validates it on frame close.
- On a valid frame, commits taps, seed and cipher enable and pulses a one-cycle load to the Galois LFSR keystream generator.
- Also forms the daisy-chain segment: cfg_o carries shifted-out bits to the next block in the chain.

Parameters:
- LFSR_W, 32, LFSR width; frame length FRAME_W = 2*LFSR_W+1.
- DEFAULT_TAPS, 32'h00000060, taps value after reset.
- DEFAULT_SEED, 32'h00000001, seed value after reset; must be non-zero.
- DEFAULT_EN, 1'b0, cipher_en value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_en  input  1  frame envelope; high while bits are shifted in.
- cfg_i  input  1  serial config data, MSB first, sampled while cfg_en=1.
- cfg_o  output  1  chain output, = shift register bit FRAME_W-1.
- cfg_err_clr  input  1  clears the cfg_err flag.
- taps  output  LFSR_W  committed LFSR feedback taps.
- seed  output  LFSR_W  committed LFSR seed.
- cipher_en  output  1  committed cipher enable.
- lfsr_load  output  1  one-cycle pulse: LFSR reloads from seed/taps.
- cfg_busy  output  1  high when state != IDLE.
- cfg_err  output  1  sticky flag: a frame was rejected.

Behaviour:
- Frame layout, shifted MSB first: bit[64] cipher_en, bits[63:32] seed, bits[31:0] taps.
- Reset values:
  - taps=DEFAULT_TAPS, seed=DEFAULT_SEED, cipher_en=DEFAULT_EN.
  - shift register=0, bit counter=0, cfg_o=0, lfsr_load=0, cfg_err=0.
  - State=IDLE, cfg_busy=0.
- Shift: sr <= {sr[FRAME_W-2:0], cfg_i} on each edge where cfg_en=1 and state is IDLE or SHIFT.
- Bit counter: 7-bit, increments on every shift, saturates at 127.
- cfg_o: a bit entering at edge k leaves at cfg_o after edge k+FRAME_W-1, i.e. the chain delay is FRAME_W shifts.
- FSM states: IDLE, SHIFT, CHECK, LOAD.
  - IDLE: cfg_en=1 -> SHIFT. Shift that edge, counter := 1.
  - SHIFT: cfg_en=1 -> shift and stay. cfg_en=0 -> CHECK; no shift that edge.
  - CHECK: always exits next edge.
    - Valid (count==FRAME_W and sr[63:32]!=0) -> LOAD. taps/seed/cipher_en update from sr, lfsr_load<=1.
    - Otherwise -> IDLE, cfg_err<=1, committed values unchanged.
    - Counter cleared on exit.
  - LOAD: lfsr_load<=0, -> IDLE.
- Latency: cfg_en sampled low at edge N -> outputs and lfsr_load=1 visible after edge N+1 -> lfsr_load=0 after edge N+2.
- cfg_en in CHECK/LOAD is ignored; no shift, bits are lost. The host keeps cfg_en low for >=2 cycles between frames.
- Short frame (<65), long frame (>65, including saturated counts) and all-zero seed are each rejected.
- Rejection of a long frame still leaves the surplus bits passed to cfg_o; the chain is unaffected.
- cfg_err stays set until cfg_err_clr=1. If set and clear occur in the same edge, set wins.
- rst mid-frame or mid-LOAD: all reset values; the partial frame is discarded; no lfsr_load pulse.
- Committed outputs change only on the CHECK->LOAD edge; they are stable at all other times.

Test Plan:
- Reset -> taps=0x00000060, seed=0x00000001, cipher_en=0, lfsr_load=0, cfg_busy=0, cfg_err=0, cfg_o=0.
- Valid 65-bit frame {1, 0x0000ACE1, 0x80200003}, then cfg_en low -> after 2 edges taps=0x80200003, seed=0x0000ACE1, cipher_en=1; lfsr_load high exactly 1 cycle; cfg_err=0.
- 64-bit frame, then 66-bit frame -> cfg_err=1 after each; outputs keep prior values; no lfsr_load. cfg_err_clr=1 -> cfg_err=0.
- 65-bit frame with seed field 0x00000000 -> rejected, cfg_err=1, seed unchanged.
- Pass-through: shift 130 bits, the first 65 being pattern P -> cfg_o reproduces P starting after edge 65, bit-exact. The frame is rejected (count saturates past 65).
- rst asserted at bit 40 of a valid frame -> reset values; cfg_en held low afterwards gives no load; a following valid frame loads normally.
- cfg_err_clr asserted in the same edge as a rejection -> cfg_err=1.
